except_ctrl: RTL and testbench

Pipeline exception controller that sequences the CP0 register file and the pipeline on every exception, interrupt and ERET. It samples raw exception flags from the MEM stage and compares them against the CP0 Status/Cause/EPC/EBase values. It then emits a one-cycle excepttype/PC/delay-slot record to CP0 and flushes the pipeline to the handler or EPC. It also owns stall generation for the IF/ID/EX/MEM/WB stages and an interrupt hold-off window after every redirect.

---
 rtl/except_ctrl_if.sv | 36 +++
 rtl/except_ctrl.sv | 94 +++++++++
 tb/tb_except_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/except_ctrl_if.sv
// rtl/except_ctrl_if.sv - pipeline/CP0 signal bundle for the exception controller
interface except_ctrl_if;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic        exc_syscall_i;
  logic        exc_inst_invalid_i;
  logic        exc_ov_i;
  logic        exc_eret_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic [31:0] cp0_ebase_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    output stallreq_id_i, stallreq_ex_i, mem_valid_i, mem_pc_i, mem_in_delayslot_i,
           exc_syscall_i, exc_inst_invalid_i, exc_ov_i, exc_eret_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, stall_o, flush_o, new_pc_o
  );

  modport slave (
    input  stallreq_id_i, stallreq_ex_i, mem_valid_i, mem_pc_i, mem_in_delayslot_i,
           exc_syscall_i, exc_inst_invalid_i, exc_ov_i, exc_eret_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o, stall_o, flush_o, new_pc_o
  );
endinterface

// File: rtl/except_ctrl.sv
// rtl/except_ctrl.sv - exception/interrupt/ERET sequencer with stall generation and interrupt hold-off
module except_ctrl #(
  parameter int INT_HOLDOFF = 2
) (
  input logic          clk,
  input logic          rst,
  except_ctrl_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] TAKE = 1'b1;

  localparam logic [31:0] CODE_INT     = 32'h01;
  localparam logic [31:0] CODE_SYSCALL = 32'h08;
  localparam logic [31:0] CODE_INVALID = 32'h0a;
  localparam logic [31:0] CODE_OV      = 32'h0c;
  localparam logic [31:0] CODE_ERET    = 32'h0e;

  logic [0:0]  state;
  logic [3:0]  holdoff;
  logic [31:0] code_q;
  logic [31:0] pc_q;
  logic        ds_q;
  logic        int_pending;
  logic [31:0] sel_code;
  logic        take_now;
  logic        in_take;

  always_comb begin
    int_pending = bus.cp0_status_i[0] && !bus.cp0_status_i[1] &&
                  ((bus.cp0_cause_i[15:8] & bus.cp0_status_i[15:8]) != 8'h00) &&
                  (holdoff == 4'd0) && bus.mem_valid_i;
  end

  always_comb begin
    sel_code = 32'h0;
    if (bus.mem_valid_i) begin
      if (int_pending)                 sel_code = CODE_INT;
      else if (bus.exc_inst_invalid_i) sel_code = CODE_INVALID;
      else if (bus.exc_syscall_i)      sel_code = CODE_SYSCALL;
      else if (bus.exc_ov_i)           sel_code = CODE_OV;
      else if (bus.exc_eret_i)         sel_code = CODE_ERET;
    end
  end

  assign in_take  = (state == TAKE);
  assign take_now = (state == IDLE) && (sel_code != 32'h0);

  // Stall is gated by rst so a held reset never freezes the pipeline.
  always_comb begin
    bus.stall_o = 6'b000000;
    if (!rst && state == IDLE) begin
      if (take_now)               bus.stall_o = 6'b111111;
      else if (bus.stallreq_ex_i) bus.stall_o = 6'b001111;
      else if (bus.stallreq_id_i) bus.stall_o = 6'b000111;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      holdoff <= 4'd0;
      code_q  <= 32'h0;
      pc_q    <= 32'h0;
      ds_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (holdoff != 4'd0) holdoff <= holdoff - 4'd1;
          if (take_now) begin
            code_q <= sel_code;
            pc_q   <= bus.mem_pc_i;
            ds_q   <= bus.mem_in_delayslot_i;
            state  <= TAKE;
          end
        end
        default: begin
          holdoff <= INT_HOLDOFF[3:0];
          state   <= IDLE;
        end
      endcase
    end
  end

  // The address/delay-slot latches only move on a new cause, so they hold between records.
  assign bus.excepttype_o        = in_take ? code_q : 32'h0;
  assign bus.current_inst_addr_o = pc_q;
  assign bus.is_in_delayslot_o   = ds_q;
  assign bus.flush_o             = in_take;
  assign bus.new_pc_o            = !in_take ? 32'h0 :
                                   (code_q == CODE_ERET) ? bus.cp0_epc_i :
                                   {bus.cp0_ebase_i[31:12], 12'h180};

endmodule

// File: tb/tb_except_ctrl.sv
// tb/tb_except_ctrl.sv - scoreboard bench for except_ctrl
module tb_except_ctrl;

  logic clk;
  logic rst;
  except_ctrl_if b();

  except_ctrl #(.INT_HOLDOFF(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] et;
    logic [31:0] addr;
    logic        ds;
    logic [31:0] npc;
  } rec_t;

  rec_t q[$];
  rec_t r;
  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] et, input logic [31:0] addr, input logic ds,
                      input logic [31:0] npc);
    rec_t x;
    x.et = et; x.addr = addr; x.ds = ds; x.npc = npc;
    q.push_back(x);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clr();
    b.stallreq_id_i      = 1'b0;
    b.stallreq_ex_i      = 1'b0;
    b.mem_valid_i        = 1'b0;
    b.mem_in_delayslot_i = 1'b0;
    b.exc_syscall_i      = 1'b0;
    b.exc_inst_invalid_i = 1'b0;
    b.exc_ov_i           = 1'b0;
    b.exc_eret_i         = 1'b0;
  endtask

  // Monitor: every flush pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (!rst && b.flush_o) begin
      if (q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_flush: got excepttype %h expected no flush", b.excepttype_o);
      end else begin
        r = q.pop_front();
        chk("rec_excepttype", b.excepttype_o, r.et);
        chk("rec_addr", b.current_inst_addr_o, r.addr);
        chk("rec_delayslot", {31'h0, b.is_in_delayslot_o}, {31'h0, r.ds});
        chk("rec_new_pc", b.new_pc_o, r.npc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clr();
    b.mem_pc_i     = 32'h0;
    b.cp0_status_i = 32'h0;
    b.cp0_cause_i  = 32'h0;
    b.cp0_epc_i    = 32'h0;
    b.cp0_ebase_i  = 32'h8000_0000;
    b.stallreq_ex_i = 1'b1;
    mid();
    chk("rst_stall", {26'h0, b.stall_o}, 32'h0);
    chk("rst_flush", {31'h0, b.flush_o}, 32'h0);
    chk("rst_excepttype", b.excepttype_o, 32'h0);
    chk("rst_addr", b.current_inst_addr_o, 32'h0);
    chk("rst_ds", {31'h0, b.is_in_delayslot_o}, 32'h0);
    chk("rst_new_pc", b.new_pc_o, 32'h0);
    next();
    rst = 1'b0;
    clr();
    next();

    // Syscall
    b.mem_valid_i = 1'b1; b.exc_syscall_i = 1'b1; b.mem_pc_i = 32'h8000_0100;
    mid(); chk("sys_stall", {26'h0, b.stall_o}, 32'h3f);
    push(32'h08, 32'h8000_0100, 1'b0, 32'h8000_0180);
    next(); clr();
    mid(); chk("sys_take_stall", {26'h0, b.stall_o}, 32'h0);
    next();
    mid();
    chk("sys_after_flush", {31'h0, b.flush_o}, 32'h0);
    chk("sys_after_et", b.excepttype_o, 32'h0);
    chk("sys_after_npc", b.new_pc_o, 32'h0);
    chk("sys_after_stall", {26'h0, b.stall_o}, 32'h0);
    chk("sys_after_addr_hold", b.current_inst_addr_o, 32'h8000_0100);
    next();

    // ERET
    b.cp0_epc_i = 32'h8000_0204;
    b.mem_valid_i = 1'b1; b.exc_eret_i = 1'b1; b.mem_pc_i = 32'h8000_0500;
    mid(); chk("eret_stall", {26'h0, b.stall_o}, 32'h3f);
    push(32'h0e, 32'h8000_0500, 1'b0, 32'h8000_0204);
    next(); clr(); mid(); next();
    for (int i = 0; i < 4; i++) next();

    // Priority: interrupt beats everything
    b.cp0_status_i = 32'h0000_0401; b.cp0_cause_i = 32'h0000_0400;
    b.mem_valid_i = 1'b1; b.exc_inst_invalid_i = 1'b1; b.exc_syscall_i = 1'b1; b.exc_ov_i = 1'b1;
    b.mem_in_delayslot_i = 1'b1; b.mem_pc_i = 32'h8000_0600;
    mid(); chk("prio_int_stall", {26'h0, b.stall_o}, 32'h3f);
    push(32'h01, 32'h8000_0600, 1'b1, 32'h8000_0180);
    next(); clr(); mid(); next();

    // Priority with interrupts disabled: invalid wins
    b.cp0_status_i = 32'h0000_0400;
    b.mem_valid_i = 1'b1; b.exc_inst_invalid_i = 1'b1; b.exc_syscall_i = 1'b1; b.exc_ov_i = 1'b1;
    b.mem_pc_i = 32'h8000_0640;
    mid(); push(32'h0a, 32'h8000_0640, 1'b0, 32'h8000_0180);
    next(); clr(); mid(); next();
    for (int i = 0; i < 4; i++) next();

    // Interrupt pending without a valid MEM instruction waits
    b.cp0_status_i = 32'h0000_0401; b.cp0_cause_i = 32'h0000_0400; b.mem_pc_i = 32'h8000_0680;
    mid(); chk("int_bubble_stall", {26'h0, b.stall_o}, 32'h0);
    next();
    b.mem_valid_i = 1'b1;
    mid(); chk("int_valid_stall", {26'h0, b.stall_o}, 32'h3f);
    push(32'h01, 32'h8000_0680, 1'b0, 32'h8000_0180);
    next(); clr(); b.cp0_status_i = 32'h0; b.cp0_cause_i = 32'h0; mid(); next();
    for (int i = 0; i < 4; i++) next();

    // Holdoff: syscall TAKE at T, interrupt accepted at T+3, TAKE at T+4
    b.mem_valid_i = 1'b1; b.exc_syscall_i = 1'b1; b.mem_pc_i = 32'h8000_0300;
    mid(); push(32'h08, 32'h8000_0300, 1'b0, 32'h8000_0180);
    next();
    b.exc_syscall_i = 1'b0; b.cp0_status_i = 32'h0000_0401; b.cp0_cause_i = 32'h0000_0400;
    mid(); next();
    mid(); chk("holdoff_t1_stall", {26'h0, b.stall_o}, 32'h0); next();
    mid(); chk("holdoff_t2_stall", {26'h0, b.stall_o}, 32'h0); next();
    mid(); chk("holdoff_t3_stall", {26'h0, b.stall_o}, 32'h3f);
    push(32'h01, 32'h8000_0300, 1'b0, 32'h8000_0180);
    next();
    clr(); b.cp0_status_i = 32'h0; b.cp0_cause_i = 32'h0;
    mid(); next();
    b.mem_valid_i = 1'b1; b.exc_syscall_i = 1'b1; b.mem_pc_i = 32'h8000_0400;
    mid(); chk("holdoff_sys_stall", {26'h0, b.stall_o}, 32'h3f);
    push(32'h08, 32'h8000_0400, 1'b0, 32'h8000_0180);
    next(); clr(); mid(); next();

    // Stalls, then overflow on top of both stall requests
    b.cp0_ebase_i = 32'hbfc0_0abc; b.mem_pc_i = 32'h8000_0700;
    b.stallreq_ex_i = 1'b1;
    mid(); chk("stall_ex", {26'h0, b.stall_o}, 32'h0f); next();
    b.stallreq_ex_i = 1'b0; b.stallreq_id_i = 1'b1;
    mid(); chk("stall_id", {26'h0, b.stall_o}, 32'h07); next();
    b.stallreq_ex_i = 1'b1;
    mid(); chk("stall_both", {26'h0, b.stall_o}, 32'h0f); next();
    b.mem_valid_i = 1'b1; b.exc_ov_i = 1'b1; b.mem_in_delayslot_i = 1'b1;
    mid(); chk("stall_ov", {26'h0, b.stall_o}, 32'h3f);
    push(32'h0c, 32'h8000_0700, 1'b1, 32'hbfc0_0180);
    next();
    b.mem_valid_i = 1'b0; b.exc_ov_i = 1'b0; b.mem_in_delayslot_i = 1'b0;
    mid(); chk("stall_in_take", {26'h0, b.stall_o}, 32'h0);
    next(); clr(); mid(); next();

    // Async reset during TAKE
    b.mem_valid_i = 1'b1; b.exc_syscall_i = 1'b1; b.mem_pc_i = 32'h8000_0800;
    mid(); chk("rsttake_stall", {26'h0, b.stall_o}, 32'h3f);
    next(); clr();
    #1 rst = 1'b1;
    #1;
    chk("rsttake_flush", {31'h0, b.flush_o}, 32'h0);
    chk("rsttake_et", b.excepttype_o, 32'h0);
    chk("rsttake_addr", b.current_inst_addr_o, 32'h0);
    chk("rsttake_npc", b.new_pc_o, 32'h0);
    mid(); next();
    rst = 1'b0;
    mid(); chk("rsttake_after_flush", {31'h0, b.flush_o}, 32'h0);
    chk("rsttake_after_stall", {26'h0, b.stall_o}, 32'h0);
    next(); mid(); next();

    chk("queue_empty", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
